// File: rtl/period_meter.sv
// period_meter
//
// Measures a slow periodic input in in_clk cycles. For each complete cycle
// of sig_in (rising edge to rising edge) it reports the full period and the
// number of cycles the signal was high. Both results update together with a
// one-cycle period_valid strobe. If no rising edge arrives within MAX_PERIOD
// cycles of the last counted edge, stalled is raised. It stays high until the
// next valid measurement.
//
// Ports
//   in_clk        system clock; all logic on its rising edge
//   rst_n         asynchronous active-low reset
//   sig_in        measured signal, asynchronous to in_clk
//   period        cycles between the last two rising edges (registered)
//   high_time     cycles sig_in was high within that period (registered)
//   period_valid  one-cycle pulse when period/high_time update
//   stalled       set on timeout, cleared by the next valid measurement
//
// The FSM state is held in the register 'state' (IDLE/ARM/MEASURE). Checkers
// and probes can observe it there.

module period_meter #(
  parameter int WIDTH      = 27,
  parameter int MAX_PERIOD = 100_000_000
) (
  input  logic             in_clk,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             period_valid,
  output logic             stalled
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_PERIOD);

  state_t           state;
  logic             s1;
  logic             s2;
  logic             s3;
  logic [1:0]       prime;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] hcnt;
  logic             rise;

  // s2 is the synchronized level. s3 delays it once more so that a rising
  // edge is seen for exactly one cycle.
  assign rise = s2 & ~s3;

  // 'prime' marks when s2 holds a real sample rather than its reset zero.
  // Without it, IDLE would read that reset zero as "input is low". A signal
  // already high at reset release would then be counted as a rising edge.
  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      prime <= 2'b00;
    end else begin
      s1    <= sig_in;
      s2    <= s1;
      s3    <= s2;
      prime <= {prime[0], 1'b1};
    end
  end

  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      hcnt         <= '0;
      period       <= '0;
      high_time    <= '0;
      period_valid <= 1'b0;
      stalled      <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      case (state)
        // Wait for a genuinely low input. Then the next rising edge is a
        // real edge.
        IDLE: begin
          if (prime[1] && !s2) begin
            state <= ARM;
          end
        end

        // The first edge only starts counting. The rising-edge cycle is
        // itself a high cycle, so both counters start at 1.
        ARM: begin
          if (rise) begin
            state <= MEASURE;
            cnt   <= ONE;
            hcnt  <= ONE;
          end
        end

        MEASURE: begin
          // If an edge and the limit arrive together, the edge wins. The
          // result is a valid measurement with period == MAX_PERIOD.
          if (rise) begin
            period       <= cnt;
            high_time    <= hcnt;
            period_valid <= 1'b1;
            stalled      <= 1'b0;
            cnt          <= ONE;
            hcnt         <= ONE;
          end else if (cnt == MAX_CNT) begin
            // On timeout, period and high_time keep their last results.
            stalled <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt  <= cnt + ONE;
            hcnt <= hcnt + {{(WIDTH-1){1'b0}}, s2};
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter
//
// Testbench for period_meter, built with WIDTH=16 and MAX_PERIOD=50.
//
// Each scenario first describes sig_in as a list of samples, one per clock
// (w[]). A reference model then walks the rising edges of that list:
//   - after reset, wait for a low sample;
//   - the next rising edge arms the meter;
//   - every later edge within MAX_PERIOD cycles of the previous one gives
//     period = edge distance and high_time = number of ones in between;
//   - otherwise a timeout occurs at MAX_PERIOD, and the wait for a low
//     sample starts again.
// From this walk the model queues the expected output for every sample.
// The sample driven on the falling edge at reset release reaches the
// measuring logic two clocks later. Its effect is therefore seen at the
// third falling edge. For that reason the first two expected outputs are
// the reset values.
//
// Some scenarios also check fixed values stated directly for the scenario,
// such as a pulse count or the spacing between two events.

module tb_period_meter;

  localparam int W    = 16;
  localparam int MAXP = 50;
  localparam int NMAX = 1024;
  localparam int TW   = 2 * W + 2;

  logic         in_clk = 1'b0;
  logic         rst_n  = 1'b1;
  logic         sig_in = 1'b0;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         period_valid;
  logic         stalled;

  int checks = 0;
  int errors = 0;

  bit              w[NMAX];
  int              wlen;
  logic [TW-1:0]   exp_q[$];

  period_meter #(
    .WIDTH      (W),
    .MAX_PERIOD (MAXP)
  ) dut (
    .in_clk       (in_clk),
    .rst_n        (rst_n),
    .sig_in       (sig_in),
    .period       (period),
    .high_time    (high_time),
    .period_valid (period_valid),
    .stalled      (stalled)
  );

  // ---------------- clock ----------------
  always #5 in_clk = ~in_clk;

  // ---------------- waveform construction ----------------
  function automatic void wave_clear();
    wlen = 0;
  endfunction

  function automatic void add_seg(bit v, int len);
    for (int i = 0; i < len; i++) begin
      if (wlen < NMAX) begin
        w[wlen] = v;
        wlen++;
      end
    end
  endfunction

  function automatic string fmt(logic [TW-1:0] o);
    return $sformatf("valid=%b stalled=%b period=%0d high=%0d",
                     o[TW-1], o[TW-2], o[2*W-1:W], o[W-1:0]);
  endfunction

  // ---------------- reference model ----------------
  function automatic void build_expected();
    bit           ev_valid[NMAX];
    bit           ev_stall[NMAX];
    int           ev_p[NMAX];
    int           ev_h[NMAX];
    int           pos;
    int           start;
    int           r2;
    bit           done;
    logic [W-1:0] p;
    logic [W-1:0] h;
    logic         st;

    for (int s = 0; s < NMAX; s++) begin
      ev_valid[s] = 1'b0;
      ev_stall[s] = 1'b0;
      ev_p[s]     = 0;
      ev_h[s]     = 0;
    end
    pos  = 0;
    done = 1'b0;
    while (!done) begin
      // waiting for a low level
      while (pos < wlen && w[pos]) pos++;
      // armed from the following sample: first rising edge
      start = -1;
      for (int s = pos + 1; s < wlen; s++) begin
        if (w[s] && !w[s-1]) begin
          start = s;
          break;
        end
      end
      if (start < 0) break;
      // measuring: successive edges, or a timeout
      pos = -1;
      while (pos < 0 && !done) begin
        r2 = -1;
        for (int s = start + 1; s <= start + MAXP && s < wlen; s++) begin
          if (w[s] && !w[s-1]) begin
            r2 = s;
            break;
          end
        end
        if (r2 >= 0) begin
          ev_valid[r2] = 1'b1;
          ev_p[r2]     = r2 - start;
          for (int k = start; k < r2; k++) ev_h[r2] += int'(w[k]);
          start = r2;
        end else if (start + MAXP < wlen) begin
          ev_stall[start + MAXP] = 1'b1;
          pos = start + MAXP + 1;
        end else begin
          done = 1'b1;
        end
      end
    end

    exp_q.delete();
    exp_q.push_back('0);
    exp_q.push_back('0);
    p  = '0;
    h  = '0;
    st = 1'b0;
    for (int s = 0; s < wlen; s++) begin
      if (ev_valid[s]) begin
        p  = W'(ev_p[s]);
        h  = W'(ev_h[s]);
        st = 1'b0;
      end
      if (ev_stall[s]) st = 1'b1;
      exp_q.push_back({ev_valid[s], st, p, h});
    end
  endfunction

  // ---------------- driver tasks ----------------
  // Apply reset with the first sample on the input. Release it on a falling
  // edge; the caller then drives w[0] at that same edge.
  task automatic start_scenario();
    rst_n  = 1'b0;
    sig_in = w[0];
    repeat (3) @(negedge in_clk);
    rst_n = 1'b1;
  endtask

  task automatic step_io(input bit v, output logic [TW-1:0] obs);
    sig_in = v;
    @(negedge in_clk);
    obs = {period_valid, stalled, period, high_time};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [TW-1:0] obs;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step_io(1'($urandom_range(0, 1)), obs);
      checks++;
      if (obs !== '0) begin
        errors++;
        $display("FAIL reset[%0d]: got %s, want all zero", i, fmt(obs));
      end
    end
  endtask

  task automatic test_divider();
    logic [TW-1:0] obs;
    logic [TW-1:0] exp;
    int            n_good = 0;
    wave_clear();
    add_seg(0, 4);
    repeat (6) begin
      add_seg(1, 6);
      add_seg(0, 4);
    end
    build_expected();
    start_scenario();
    for (int i = 0; i < wlen + 2; i++) begin
      step_io(w[(i < wlen) ? i : wlen - 1], obs);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL divider[%0d]: got %s, want %s", i, fmt(obs), fmt(exp));
      end
      if (obs[TW-1] && obs[2*W-1:W] == 10 && obs[W-1:0] == 6) n_good++;
    end
    checks++;
    if (n_good != 5) begin
      errors++;
      $display("FAIL divider_count: got %0d pulses of 10/6, want 5", n_good);
    end
  endtask

  task automatic test_high_at_reset();
    logic [TW-1:0] obs;
    logic [TW-1:0] exp;
    logic [TW-1:0] first_v = '0;
    int            n_v = 0;
    wave_clear();
    add_seg(1, 6);
    add_seg(0, 5);
    repeat (4) begin
      add_seg(1, 4);
      add_seg(0, 4);
    end
    build_expected();
    start_scenario();
    for (int i = 0; i < wlen + 2; i++) begin
      step_io(w[(i < wlen) ? i : wlen - 1], obs);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL high_at_reset[%0d]: got %s, want %s", i, fmt(obs), fmt(exp));
      end
      if (obs[TW-1]) begin
        if (n_v == 0) first_v = obs;
        n_v++;
      end
    end
    checks++;
    if (n_v != 3 || first_v[2*W-1:W] != 8 || first_v[W-1:0] != 4) begin
      errors++;
      $display("FAIL high_at_reset_first: got %0d pulses, first %s, want 3 pulses, first period=8 high=4",
               n_v, fmt(first_v));
    end
  endtask

  task automatic test_timeout_recovery();
    logic [TW-1:0] obs;
    logic [TW-1:0] exp;
    int            stall_idx = -1;
    int            vld_idx   = -1;
    bit            prev_st   = 1'b0;
    bit            p20_ok    = 1'b0;
    wave_clear();
    add_seg(0, 5);  add_seg(1, 4);  add_seg(0, 8);
    add_seg(1, 4);  add_seg(0, 8);  add_seg(1, 3);
    add_seg(0, 60);
    add_seg(1, 5);  add_seg(0, 15); add_seg(1, 5); add_seg(0, 10);
    build_expected();
    start_scenario();
    for (int i = 0; i < wlen + 2; i++) begin
      step_io(w[(i < wlen) ? i : wlen - 1], obs);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL timeout[%0d]: got %s, want %s", i, fmt(obs), fmt(exp));
      end
      if (stall_idx < 0 && obs[TW-1]) vld_idx = i;
      if (stall_idx < 0 && obs[TW-2]) stall_idx = i;
      if (obs[TW-1] && obs[2*W-1:W] == 20) p20_ok = prev_st && !obs[TW-2];
      prev_st = obs[TW-2];
    end
    checks++;
    if (stall_idx < 0 || vld_idx < 0 || stall_idx - vld_idx != MAXP) begin
      errors++;
      $display("FAIL timeout_delay: got stall %0d cycles after last edge, want %0d",
               stall_idx - vld_idx, MAXP);
    end
    checks++;
    if (!p20_ok) begin
      errors++;
      $display("FAIL timeout_recover: got no period=20 pulse clearing stalled, want one");
    end
  endtask

  task automatic test_exact_max();
    logic [TW-1:0] obs;
    logic [TW-1:0] exp;
    int            n_good  = 0;
    int            n_stall = 0;
    wave_clear();
    add_seg(0, 5);
    add_seg(1, 10); add_seg(0, 40);
    add_seg(1, 10); add_seg(0, 40);
    add_seg(1, 10); add_seg(0, 5);
    build_expected();
    start_scenario();
    for (int i = 0; i < wlen + 2; i++) begin
      step_io(w[(i < wlen) ? i : wlen - 1], obs);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL exact_max[%0d]: got %s, want %s", i, fmt(obs), fmt(exp));
      end
      if (obs[TW-1] && obs[2*W-1:W] == MAXP && obs[W-1:0] == 10) n_good++;
      if (obs[TW-2]) n_stall++;
    end
    checks++;
    if (n_good != 2 || n_stall != 0) begin
      errors++;
      $display("FAIL exact_max_count: got %0d pulses, %0d stalled cycles, want 2 pulses, 0 stalled",
               n_good, n_stall);
    end
  endtask

  task automatic test_period_two();
    logic [TW-1:0] obs;
    logic [TW-1:0] exp;
    int            n_good = 0;
    int            consec = 0;
    bit            prev_v = 1'b0;
    wave_clear();
    add_seg(0, 3);
    repeat (20) begin
      add_seg(1, 1);
      add_seg(0, 1);
    end
    build_expected();
    start_scenario();
    for (int i = 0; i < wlen + 2; i++) begin
      step_io(w[(i < wlen) ? i : wlen - 1], obs);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL period_two[%0d]: got %s, want %s", i, fmt(obs), fmt(exp));
      end
      if (obs[TW-1] && obs[2*W-1:W] == 2 && obs[W-1:0] == 1) n_good++;
      if (obs[TW-1] && prev_v) consec++;
      prev_v = obs[TW-1];
    end
    checks++;
    if (n_good != 19 || consec != 0) begin
      errors++;
      $display("FAIL period_two_count: got %0d pulses, %0d back-to-back, want 19 pulses, 0 back-to-back",
               n_good, consec);
    end
  endtask

  task automatic test_reset_mid_period();
    logic [TW-1:0] obs;
    logic [TW-1:0] exp;
    logic [TW-1:0] hold_exp;
    int            first_idx = -1;
    wave_clear();
    add_seg(0, 4);
    repeat (3) begin
      add_seg(1, 6);
      add_seg(0, 4);
    end
    build_expected();
    start_scenario();
    for (int i = 0; i < wlen + 2; i++) begin
      step_io(w[(i < wlen) ? i : wlen - 1], obs);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL mid_reset_pre[%0d]: got %s, want %s", i, fmt(obs), fmt(exp));
      end
    end
    // Check the held result, then assert reset between clock edges.
    @(posedge in_clk);
    #1;
    hold_exp = {1'b0, 1'b0, 16'd10, 16'd6};
    obs = {period_valid, stalled, period, high_time};
    checks++;
    if (obs !== hold_exp) begin
      errors++;
      $display("FAIL mid_reset_hold: got %s, want %s", fmt(obs), fmt(hold_exp));
    end
    #1;
    rst_n = 1'b0;
    #1;
    obs = {period_valid, stalled, period, high_time};
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL mid_reset_async: got %s, want all zero", fmt(obs));
    end
    // Restart after a reset held for 3 cycles.
    wave_clear();
    add_seg(0, 3);
    repeat (4) begin
      add_seg(1, 5);
      add_seg(0, 5);
    end
    build_expected();
    start_scenario();
    for (int i = 0; i < wlen + 2; i++) begin
      step_io(w[(i < wlen) ? i : wlen - 1], obs);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL mid_reset_post[%0d]: got %s, want %s", i, fmt(obs), fmt(exp));
      end
      if (first_idx < 0 && obs[TW-1]) first_idx = i;
    end
    // Edges are at samples 3 and 13. The second one gives the first result,
    // seen two falling edges later.
    checks++;
    if (first_idx != 15) begin
      errors++;
      $display("FAIL mid_reset_first: got first pulse at %0d, want 15", first_idx);
    end
  endtask

  task automatic test_random();
    logic [TW-1:0] obs;
    logic [TW-1:0] exp;
    wave_clear();
    if ($urandom_range(0, 1) == 1) add_seg(1, int'($urandom_range(1, 10)));
    while (wlen < 600) begin
      add_seg(0, ($urandom_range(0, 7) == 0) ? int'($urandom_range(45, 70))
                                              : int'($urandom_range(1, 20)));
      add_seg(1, ($urandom_range(0, 11) == 0) ? int'($urandom_range(45, 70))
                                               : int'($urandom_range(1, 20)));
    end
    build_expected();
    start_scenario();
    for (int i = 0; i < wlen + 2; i++) begin
      step_io(w[(i < wlen) ? i : wlen - 1], obs);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL random[%0d]: got %s, want %s", i, fmt(obs), fmt(exp));
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0;
    test_reset();
    test_divider();
    test_high_at_reset();
    test_timeout_recovery();
    test_exact_max();
    test_period_two();
    test_reset_mid_period();
    repeat (2) test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
